// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract, LSB first; optional saturation under SERIAL_ADDSUB_SATURATE_EN.
// Latency: result valid WIDTH cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             sub_q, c_q, carry_q, ovf_q;
  logic [CW-1:0]    cnt;

  logic             last_bit;
  logic             op_a, op_b, s_bit, c_out, ovf_fin;
  logic [WIDTH-1:0] sum_raw, sum_fin;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    op_a    = a_q[cnt];
    op_b    = b_q[cnt] ^ sub_q;
    s_bit   = op_a ^ op_b ^ c_q;
    c_out   = (op_a & op_b) | (op_a & c_q) | (op_b & c_q);
    // c_q is the carry into the MSB when the last bit is processed
    ovf_fin = c_q ^ c_out;
    sum_raw = sum_q;
    sum_raw[cnt] = s_bit;
`ifdef SERIAL_ADDSUB_SATURATE_EN
    if (ovf_fin) begin
      sum_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_fin = sum_raw;
    end
`else
    sum_fin = sum_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            c_q     <= sub;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        CALC: begin
          if (last_bit) begin
            sum_q   <= sum_fin;
            carry_q <= c_out;
            ovf_q   <= ovf_fin;
          end else begin
            sum_q <= sum_raw;
            c_q   <= c_out;
            cnt   <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // partial sums stay internal until the result is complete
  assign sum       = out_valid ? sum_q   : '0;
  assign carry     = out_valid ? carry_q : 1'b0;
  assign overflow  = out_valid ? ovf_q   : 1'b0;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=4): directed cases plus randomized ops vs an arithmetic model.
module tb_serial_addsub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         sub = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, carry, overflow, out_valid;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sub(sub), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .carry(carry), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Reference model from plain integer arithmetic
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    int ua, ub, tot, sa, sb, sr, mx, mn;
    ua  = int'(ta);
    ub  = int'(tb_);
    tot = ts ? (ua + ((~ub) & ((1 << W) - 1)) + 1) : (ua + ub);
    es  = tot[W-1:0];
    ec  = tot[W];
    sa  = ta[W-1] ? ua - (1 << W) : ua;
    sb  = tb_[W-1] ? ub - (1 << W) : ub;
    sr  = ts ? sa - sb : sa + sb;
    mx  = (1 << (W - 1)) - 1;
    mn  = -(1 << (W - 1));
    eo  = (sr > mx) || (sr < mn);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    if (sr > mx) es = W'(mx);
    if (sr < mn) es = W'(mn);
`endif
  endtask

  // Runs one operation; reports result, latency, and observations around release
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts, input int hold,
                        output logic [W-1:0] rs, output logic rc, output logic ro, output int lat,
                        output bit done, output bit mask_bad, output logic post_ov, output logic post_ir);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; done = 0; mask_bad = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) done = 1;
      else if (sum !== '0 || carry !== 1'b0 || overflow !== 1'b0) mask_bad = 1;
    end
    @(negedge clk);
    rs = sum; rc = carry; ro = overflow;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    post_ov = out_valid;
    post_ir = in_ready;
  endtask

  task automatic test_reset();
    logic [W-1:0] rs; logic rc, ro, pov, pir; int lat; bit dn, mb;
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b sum=%b, want 0 1 0000", out_valid, in_ready, sum);
    end
    @(negedge clk) rst_n = 1'b1;
    run_op(4'd3, 4'd4, 1'b0, 0, rs, rc, ro, lat, dn, mb, pov, pir);
    checks++;
    if (!dn || lat !== W) begin
      errors++;
      $display("FAIL first_latency: done=%0d lat=%0d, want 1 %0d", dn, lat, W);
    end
    checks++;
    if (rs !== 4'b0111 || rc !== 1'b0 || ro !== 1'b0) begin
      errors++;
      $display("FAIL add_3_4: sum=%b c=%b o=%b, want 0111 0 0", rs, rc, ro);
    end
    checks++;
    if (pov !== 1'b0 || pir !== 1'b1) begin
      errors++;
      $display("FAIL release_3_4: out_valid=%b in_ready=%b, want 0 1", pov, pir);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{4'd5, 4'd0, 4'd7, 4'b1000};
    logic [W-1:0] tbv[4] = '{4'd3, 4'd1, 4'd1, 4'b0001};
    logic         tsv[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef SERIAL_ADDSUB_SATURATE_EN
    logic [W-1:0] es [4] = '{4'b0010, 4'b1111, 4'b0111, 4'b1000};
`else
    logic [W-1:0] es [4] = '{4'b0010, 4'b1111, 4'b1000, 4'b0111};
`endif
    logic         ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] rs; logic rc, ro, pov, pir; int lat; bit dn, mb;
    for (int k = 0; k < 4; k++) begin
      run_op(ta[k], tbv[k], tsv[k], 0, rs, rc, ro, lat, dn, mb, pov, pir);
      checks++;
      if (!dn || rs !== es[k] || rc !== ec[k] || ro !== eo[k]) begin
        errors++;
        $display("FAIL directed_%0d: done=%0d sum=%b c=%b o=%b, want sum=%b c=%b o=%b",
                 k, dn, rs, rc, ro, es[k], ec[k], eo[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit dn = 0;
    @(negedge clk);
    a = 4'd2; b = 4'd3; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 40 && !dn; i++) begin
      @(posedge clk); #1;
      if (out_valid) dn = 1;
    end
    checks++;
    if (!dn) begin
      errors++;
      $display("FAIL bp_done: out_valid never rose");
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = 4'd7; b = 4'd7; sub = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 4'b0101 || carry !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: ov=%b ir=%b sum=%b c=%b o=%b, want 1 0 0101 0 0",
                 cyc, out_valid, in_ready, sum, carry, overflow);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rs; logic rc, ro, pov, pir; int lat; bit dn, mb; bit seen = 0;
    @(negedge clk);
    a = 4'd6; b = 4'd5; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0) begin
      errors++;
      $display("FAIL mid_reset: ov=%b ir=%b sum=%b, want 0 1 0000", out_valid, in_ready, sum);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_abort: out_valid=1 after abort, want 0");
    end
    run_op(4'd2, 4'd2, 1'b0, 1, rs, rc, ro, lat, dn, mb, pov, pir);
    checks++;
    if (!dn || rs !== 4'b0100 || rc !== 1'b0 || ro !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_2_2: done=%0d sum=%b c=%b o=%b, want 0100 0 0", dn, rs, rc, ro);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tb_, rs, es; logic ts, rc, ro, ec, eo, pov, pir; int lat; bit dn, mb;
    for (int n = 0; n < 60; n++) begin
      ta  = W'($urandom_range(0, (1 << W) - 1));
      tb_ = W'($urandom_range(0, (1 << W) - 1));
      ts  = 1'($urandom_range(0, 1));
      model(ta, tb_, ts, es, ec, eo);
      run_op(ta, tb_, ts, int'($urandom_range(0, 2)), rs, rc, ro, lat, dn, mb, pov, pir);
      checks++;
      if (!dn || lat !== W || mb || rs !== es || rc !== ec || ro !== eo || pov !== 1'b0 || pir !== 1'b1) begin
        errors++;
        $display("FAIL rand_%0d a=%b b=%b sub=%b: done=%0d lat=%0d maskbad=%0d sum=%b c=%b o=%b post=%b%b, want sum=%b c=%b o=%b lat=%0d post=01",
                 n, ta, tb_, ts, dn, lat, mb, rs, rc, ro, pov, pir, es, ec, eo, W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
